rfphoenix_mem_req_arbiter: RTL
==============================

# rfPhoenix_mem_req_arbiter

Sequences memory requests from NREQ load/store requesters into the two write ports (wr0/i0, wr1/i1) of the memory request queue, and drains the queue head toward the memory interface. Up to two requesters are granted per cycle with round-robin fairness. Each granted request is held stable until the queue acknowledges it, and a stalled grant is released on timeout. The block sits between the per-thread memory stages and the queue, and between the queue and the bus interface unit.

## Interface
Parameters:
- NREQ, 4, number of requesters (2..8); IW = $clog2(NREQ) index width
- TMO, 15, cycles a channel waits for wr_ack before releasing its grant (1..255)

Ports:
- clk  in  1  clock
- rst  in  1  reset; **asynchronous, active-high**
- req  in  NREQ  request valid per requester; held until its ack
- reqi  in  sMemoryRequest[NREQ]  request payload per requester; stable while req is high
- ack  out  NREQ  one-cycle accept pulse per requester
- tmo_err  out  2  one-cycle pulse: channel 0/1 timed out
- wr0, wr1  out  1  queue write strobes
- i0, i1  out  sMemoryRequest  queue write payloads
- wr_ack0, wr_ack1  in  1  queue write acknowledges (registered in the queue)
- full  in  1  queue full
- qvalid  in  1  queue head valid
- qo  in  sMemoryRequest  queue head
- rd  out  1  queue pop strobe
- mem_rdy  in  1  memory interface can accept a request
- mem_req_v  out  1  memory request valid
- mem_req  out  sMemoryRequest  memory request payload

## Operation
- Two write channels, CH0→wr0/i0 and CH1→wr1/i1. Each channel has a two-state FSM, IDLE/BUSY, plus a registered grant index gidx (IW bits) and a wait counter wcnt (8 bits).
- Eligible set E = req & ~busy_mask, where busy_mask holds the gidx of every BUSY channel.
- Arbitration runs only while full=0, and runs every cycle.
  - Scan E in order rr, rr+1, …, wrapping mod NREQ.
  - The first hit goes to CH0 if CH0 is IDLE, otherwise to CH1 if CH1 is IDLE.
  - If both channels are IDLE, the second hit goes to CH1.
  - A requester is never granted to both channels.
- Grant: the channel enters BUSY, loads gidx, clears wcnt, and registers i<ch> = reqi[gidx].
- BUSY behaviour:
  - wr<ch> = BUSY & ~wr_ack<ch>. This is combinational and drops in the ack cycle so the queue cannot duplicate the entry.
  - wcnt increments each cycle.
  - If wr_ack<ch>=1: ack[gidx] = 1 combinationally that cycle, and the channel returns to IDLE next cycle.
  - Else if wcnt==TMO-1: the channel returns to IDLE, tmo_err[ch] pulses next cycle, and no ack is given. The requester stays pending and re-arbitrates.
- rr pointer:
  - Updated on any grant to (last granted index + 1) mod NREQ.
  - If both channels are granted in one cycle, the CH1 index is the one used.
  - Unchanged on timeout.
- full=1 blocks new grants only; BUSY channels continue to wait.
- Drain FSM, states D_IDLE/D_WAIT:
  - In D_IDLE with qvalid & mem_rdy: rd=1 and mem_req_v=1 for one cycle, with mem_req = qo registered. Go to D_WAIT.
  - D_WAIT lasts one cycle, letting the queue shift complete, then returns to D_IDLE.
  - rd is never high two consecutive cycles.
- Reset, async:
  - Both channels IDLE; drain FSM in D_IDLE.
  - rr=0, wcnt=0, gidx=0.
  - Outputs ack, tmo_err, wr0, wr1, rd, mem_req_v are 0; i0, i1, mem_req are 0.
  - Reset asserted mid-BUSY drops wr immediately and gives no ack.

## Timing
- req sampled high at edge N (channel IDLE, full=0) → wr high and i valid from N+1.
- wr_ack arrives at N+2 → ack pulse at N+2, wr low at N+2, channel IDLE at N+3.
- Earliest re-grant on the same channel is sampled at N+3, giving wr at N+4. Each channel sustains 1 request per 3 cycles; two channels give 2 per 3 cycles.
- Timeout: no wr_ack through N+TMO → channel IDLE and tmo_err at N+TMO+1.
- Drain: qvalid & mem_rdy at cycle M → rd and mem_req_v at M, mem_req at M+1. The next pop is possible at M+2.
- Requester contract: drop req (or present a new reqi) the cycle after ack.

## Test plan
- Reset: assert rst asynchronously mid-cycle while CH0 is BUSY → wr0, ack, rd drop at once; after release, rr=0 and every output is 0.
- Single request: req=4'b0010 at N, queue acks at N+2 → wr0 at N+1 with i0=reqi[1]; ack=4'b0010 at N+2 only; wr0 low at N+2; exactly one queue entry.
- Dual grant and fairness: req=4'b1111 held, each request acked after 2 cycles → first grants (CH0,CH1)=(0,1), then (2,3), then (0,1); each requester is acked once per 6 cycles.
- Full and timeout: full=1 at N with req=4'b0001 → no wr. With TMO=4, grant at N and wr_ack never asserted → tmo_err[0] at N+5, no ack, re-grant follows.
- Drain: qvalid=1 constant, mem_rdy toggled 1,1,0,1 → rd on cycles 0 and 3 only; mem_req equals qo registered at each pop.

Source files
------------

// File: rtl/rfphoenix_mem_req_arbiter.sv
// rtl/rfphoenix_mem_req_arbiter.sv - two-channel round-robin memory request arbiter and queue drain
module rfphoenix_mem_req_arbiter #(
    parameter int  NREQ = 4,
    parameter int  TMO  = 15,
    parameter int  PW   = 64,
    localparam int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic [NREQ-1:0] req_i,
    input  logic [PW-1:0]   reqi_i [NREQ],
    output logic [NREQ-1:0] ack_o,
    output logic [1:0]      tmo_err_o,
    output logic            wr0_o,
    output logic            wr1_o,
    output logic [PW-1:0]   i0_o,
    output logic [PW-1:0]   i1_o,
    input  logic            wr_ack0_i,
    input  logic            wr_ack1_i,
    input  logic            full_i,
    input  logic            qvalid_i,
    input  logic [PW-1:0]   qo_i,
    output logic            rd_o,
    input  logic            mem_rdy_i,
    output logic            mem_req_v_o,
    output logic [PW-1:0]   mem_req_o
);

    typedef enum logic {CH_IDLE, CH_BUSY} ch_state_e;
    typedef enum logic {D_IDLE, D_WAIT} drain_state_e;

    ch_state_e    ch_q   [2];
    ch_state_e    ch_d   [2];
    logic [IW-1:0] gidx_q [2];
    logic [IW-1:0] gidx_d [2];
    logic [7:0]   wcnt_q [2];
    logic [7:0]   wcnt_d [2];
    logic [PW-1:0] ich_q  [2];
    logic [PW-1:0] ich_d  [2];
    logic [IW-1:0] rr_q, rr_d;
    logic [1:0]   tmo_q, tmo_d;
    drain_state_e dst_q, dst_d;
    logic [PW-1:0] mreq_q, mreq_d;

    logic [1:0]    wr_ack;
    logic [1:0]    busy;
    logic [1:0]    gnt;
    logic [IW-1:0] gsel [2];

    assign wr_ack = {wr_ack1_i, wr_ack0_i};
    assign busy   = {ch_q[1] == CH_BUSY, ch_q[0] == CH_BUSY};

    function automatic logic [IW-1:0] rr_next(input logic [IW-1:0] g);
        return (int'(g) == NREQ - 1) ? '0 : g + 1'b1;
    endfunction

    // Round-robin scan of requesters not already held by a busy channel.
    always_comb begin : arb
        logic [NREQ-1:0] elig;
        logic            hit0_v, hit1_v;
        logic [IW-1:0]   hit0, hit1, idx_w;
        int              idx;
        elig   = req_i;
        hit0_v = 1'b0;
        hit1_v = 1'b0;
        hit0   = '0;
        hit1   = '0;
        idx    = 0;
        idx_w  = '0;
        for (int c = 0; c < 2; c++) begin
            if (busy[c]) elig[gidx_q[c]] = 1'b0;
        end
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(rr_q) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            idx_w = IW'(idx);
            if (elig[idx_w]) begin
                if (!hit0_v) begin
                    hit0_v = 1'b1;
                    hit0   = idx_w;
                end else if (!hit1_v) begin
                    hit1_v = 1'b1;
                    hit1   = idx_w;
                end
            end
        end
        gsel[0] = hit0;
        gsel[1] = busy[0] ? hit0 : hit1;
        gnt[0]  = ~full_i & ~busy[0] & hit0_v;
        gnt[1]  = ~full_i & ~busy[1] & (busy[0] ? hit0_v : hit1_v);
    end

    always_comb begin
        ack_o = '0;
        tmo_d = '0;
        rr_d  = rr_q;
        for (int c = 0; c < 2; c++) begin
            ch_d[c]   = ch_q[c];
            gidx_d[c] = gidx_q[c];
            wcnt_d[c] = wcnt_q[c];
            ich_d[c]  = ich_q[c];
            case (ch_q[c])
                CH_IDLE: begin
                    if (gnt[c]) begin
                        ch_d[c]   = CH_BUSY;
                        gidx_d[c] = gsel[c];
                        wcnt_d[c] = '0;
                        ich_d[c]  = reqi_i[gsel[c]];
                    end
                end
                CH_BUSY: begin
                    wcnt_d[c] = wcnt_q[c] + 8'd1;
                    if (wr_ack[c]) begin
                        ch_d[c]            = CH_IDLE;
                        ack_o[gidx_q[c]]   = 1'b1;
                    end else if (wcnt_q[c] == 8'(TMO - 1)) begin
                        ch_d[c]  = CH_IDLE;
                        tmo_d[c] = 1'b1;
                    end
                end
                default: ;
            endcase
        end
        if (gnt[1]) begin
            rr_d = rr_next(gsel[1]);
        end else if (gnt[0]) begin
            rr_d = rr_next(gsel[0]);
        end
    end

    // Strobe falls in the ack cycle so the queue never takes a duplicate entry.
    assign wr0_o     = busy[0] & ~wr_ack0_i;
    assign wr1_o     = busy[1] & ~wr_ack1_i;
    assign i0_o      = ich_q[0];
    assign i1_o      = ich_q[1];
    assign tmo_err_o = tmo_q;
    assign mem_req_o = mreq_q;

    always_comb begin
        rd_o        = 1'b0;
        mem_req_v_o = 1'b0;
        dst_d       = D_IDLE;
        mreq_d      = mreq_q;
        if (dst_q == D_IDLE) begin
            if (qvalid_i & mem_rdy_i & ~rst_i) begin
                rd_o        = 1'b1;
                mem_req_v_o = 1'b1;
                dst_d       = D_WAIT;
                mreq_d      = qo_i;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int c = 0; c < 2; c++) begin
                ch_q[c]   <= CH_IDLE;
                gidx_q[c] <= '0;
                wcnt_q[c] <= '0;
                ich_q[c]  <= '0;
            end
            rr_q   <= '0;
            tmo_q  <= '0;
            dst_q  <= D_IDLE;
            mreq_q <= '0;
        end else begin
            for (int c = 0; c < 2; c++) begin
                ch_q[c]   <= ch_d[c];
                gidx_q[c] <= gidx_d[c];
                wcnt_q[c] <= wcnt_d[c];
                ich_q[c]  <= ich_d[c];
            end
            rr_q   <= rr_d;
            tmo_q  <= tmo_d;
            dst_q  <= dst_d;
            mreq_q <= mreq_d;
        end
    end

endmodule
